sw_tail_buffer: RTL

SW_TAIL_BUFFER -- requirements
Module: sw_tail_buffer

---
 rtl/sw_tail_buffer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/sw_tail_buffer.sv
// Tail boundary buffer for the systolic SW array: collects last-PE beats into a FIFO for the
// next query segment and tracks the running maximum score. SW_TAIL_MAX_POS_EN adds max_col.
module sw_tail_buffer #(
    parameter int unsigned CALC_BIT = 16,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned AW       = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                t_valid,
    input  logic [CALC_BIT-1:0] v_in,
    input  logic [CALC_BIT-1:0] v_in_a,
    input  logic [CALC_BIT-1:0] f_in_b,
    input  logic [CALC_BIT-1:0] max_in,
    input  logic                pass_end,
    input  logic                last_pass,
    input  logic                rd_en,
    output logic [CALC_BIT-1:0] v_o,
    output logic [CALC_BIT-1:0] v_a_o,
    output logic [CALC_BIT-1:0] f_b_o,
    output logic                rd_valid,
    output logic                full,
    output logic                empty,
    output logic                busy,
    output logic [CALC_BIT-1:0] max_score,
    output logic                score_valid,
    output logic                ovf_err
`ifdef SW_TAIL_MAX_POS_EN
    ,
    output logic [15:0]         max_col
`endif
);

    localparam int unsigned EW = 3 * CALC_BIT;
    localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e              state_q, state_d;
    logic [AW-1:0]       wptr_q, rptr_q;
    logic [AW:0]         cnt_q;
    logic [EW-1:0]       mem_q [DEPTH];
    logic [CALC_BIT-1:0] v_q, va_q, fb_q, max_q;
    logic                rdv_q, ovf_q;

    logic clr, wr_req, wr_ok, rd_ok, ovf_set, raise;

    always_comb begin
        clr     = (state_q == StIdle) && start;
        wr_req  = (state_q == StCollect) && t_valid;
        rd_ok   = rd_en && (cnt_q != '0) && !clr;
        // A read in the same cycle frees the slot, so a write to a full FIFO still lands.
        wr_ok   = wr_req && ((cnt_q != FullCnt) || rd_ok);
        ovf_set = wr_req && (cnt_q == FullCnt) && !rd_ok;
        raise   = wr_req && (max_in > max_q);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start) state_d = StCollect;
            StCollect: if (pass_end && last_pass) state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            v_q     <= '0;
            va_q    <= '0;
            fb_q    <= '0;
            max_q   <= '0;
            rdv_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdv_q   <= rd_ok;
            if (clr) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
                max_q  <= '0;
                ovf_q  <= 1'b0;
            end else begin
                if (wr_ok) wptr_q <= wptr_q + AW'(1);
                if (rd_ok) begin
                    rptr_q <= rptr_q + AW'(1);
                    {v_q, va_q, fb_q} <= mem_q[rptr_q];
                end
                if (wr_ok && !rd_ok) cnt_q <= cnt_q + (AW+1)'(1);
                else if (!wr_ok && rd_ok) cnt_q <= cnt_q - (AW+1)'(1);
                if (raise) max_q <= max_in;
                if (ovf_set) ovf_q <= 1'b1;
            end
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr_q] <= {v_in, v_in_a, f_in_b};
    end

`ifdef SW_TAIL_MAX_POS_EN
    logic [15:0] col_q, max_col_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q     <= '0;
            max_col_q <= '0;
        end else if (clr) begin
            col_q     <= '0;
            max_col_q <= '0;
        end else if (wr_req) begin
            col_q <= col_q + 16'd1;
            if (raise) max_col_q <= col_q;
        end
    end

    assign max_col = max_col_q;
`endif

    assign v_o         = v_q;
    assign v_a_o       = va_q;
    assign f_b_o       = fb_q;
    assign rd_valid    = rdv_q;
    assign full        = (cnt_q == FullCnt);
    assign empty       = (cnt_q == '0);
    assign busy        = (state_q == StCollect);
    assign max_score   = max_q;
    assign score_valid = (state_q == StDone);
    assign ovf_err     = ovf_q;

endmodule
